// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU and result signals of the ALU sequencer.
// The slave modport is the sequencer's view; the master modport is the view
// of the environment around it (instruction decoder, ALU, result consumer).
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 16
);

  // Operation request from the decoder
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             update_flags;

  // ALU command and response
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;
  logic             alu_v;
  logic             alu_done;

  // Result return and architectural status
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  op_valid, opcode, operand_a, operand_b, update_flags,
    input  alu_result, alu_z, alu_n, alu_c, alu_v, alu_done,
    input  res_ready,
    output op_ready,
    output alu_op, alu_a, alu_b, alu_start,
    output res_valid, res_data,
    output flag_z, flag_n, flag_c, flag_v,
    output busy, timeout_err
  );

  modport master (
    output op_valid, opcode, operand_a, operand_b, update_flags,
    output alu_result, alu_z, alu_n, alu_c, alu_v, alu_done,
    output res_ready,
    input  op_ready,
    input  alu_op, alu_a, alu_b, alu_start,
    input  res_valid, res_data,
    input  flag_z, flag_n, flag_c, flag_v,
    input  busy, timeout_err
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one operation at a time to the 16-bit ALU, waits one
// cycle (single-cycle ops) or for alu_done (multi-cycle ops), returns the
// result over a valid/ready handshake and owns the Z/N/C/V status register.
// Optional WAIT watchdog: define ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter logic [3:0]  MULTI_OP_MIN   = 4'hC,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_op_ready;
  logic             r_busy;

  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_alu_start;
  logic             r_upd_flags;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_flag_v;

  logic             w_is_multi;
  logic             w_accept;
  logic             w_capture;
  logic             w_res_hs;
  logic             w_timeout;
  logic             w_timeout_err;

  // State register; op_ready/busy are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state logic: accept -> execute -> (wait) -> hold until consumed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.op_valid) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_is_multi) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_WAIT: begin
        if (bus.alu_done || w_timeout) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Per-state control strobes; alu_done only matters while in WAIT
  always_comb begin
    w_is_multi = (r_alu_op >= MULTI_OP_MIN);
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_res_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.op_valid;
      end
      S_EXEC: begin
        w_capture = ~w_is_multi;
      end
      S_WAIT: begin
        w_capture = bus.alu_done;
      end
      S_HOLD: begin
        w_res_hs = bus.res_ready;
      end
      default: begin
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_res_hs  = 1'b0;
      end
    endcase
  end

  // ALU command registers: loaded only on accept so the ALU inputs stay quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op    <= 4'h0;
      r_alu_a     <= {WIDTH{1'b0}};
      r_alu_b     <= {WIDTH{1'b0}};
      r_upd_flags <= 1'b0;
      r_alu_start <= 1'b0;
    end else if (w_accept) begin
      r_alu_op    <= bus.opcode;
      r_alu_a     <= bus.operand_a;
      r_alu_b     <= bus.operand_b;
      r_upd_flags <= bus.update_flags;
      // start is high exactly during the EXEC cycle of a multi-cycle op
      r_alu_start <= (bus.opcode >= MULTI_OP_MIN);
    end else begin
      r_alu_start <= 1'b0;
    end
  end

  // Result register and valid flag: set on capture/timeout, cleared on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= {WIDTH{1'b0}};
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.alu_result;
    end else if (w_timeout) begin
      r_res_valid <= 1'b1;
      r_res_data  <= {WIDTH{1'b1}};
    end else if (w_res_hs) begin
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= r_res_valid;
    end
  end

  // Status register: written only on a real capture with the update intent
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_capture && r_upd_flags) begin
      r_flag_z <= bus.alu_z;
      r_flag_n <= bus.alu_n;
      r_flag_c <= bus.alu_c;
      r_flag_v <= bus.alu_v;
    end else begin
      r_flag_z <= r_flag_z;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  // Limit hits on the TIMEOUT_CYCLES-th WAIT cycle; alu_done in that cycle wins
  assign w_timeout = (r_state == S_WAIT) && !bus.alu_done &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT cycle counter (cleared in EXEC, i.e. on entry) and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= {CNT_W{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_EXEC) begin
        r_wait_cnt <= {CNT_W{1'b0}};
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
    end
  end

  assign w_timeout_err = r_timeout_err;
`else
  // Without the watchdog, WAIT lasts until alu_done
  assign w_timeout     = 1'b0;
  assign w_timeout_err = 1'b0;
`endif

  assign bus.op_ready    = r_op_ready;
  assign bus.busy        = r_busy;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_start   = r_alu_start;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.flag_z      = r_flag_z;
  assign bus.flag_n      = r_flag_n;
  assign bus.flag_c      = r_flag_c;
  assign bus.flag_v      = r_flag_v;
  assign bus.timeout_err = w_timeout_err;

endmodule
